alu_mc: RTL
===========

Name: alu_mc

Overview:
- Parametrised multi-cycle ALU for the multicycle/pipelined datapath generations.
- Generalises the single-cycle add/sub/slt ALU to WIDTH bits.
- Adds and/or, iterative unsigned multiply and restoring unsigned divide.
- Uses a start/busy/done handshake so the controller FSM can stall on long operations. Results and flags are registered.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  operation: 000 and, 001 or, 010 add, 110 sub, 111 slt (signed), 011 mulu, 100 divu; 101 is illegal.
- inp1  input  WIDTH  operand A / dividend / multiplicand.
- inp2  input  WIDTH  operand B / divisor / multiplier.
- busy  output  1  iterative operation in progress.
- done  output  1  one-cycle pulse: out/out_hi/flags valid.
- out  output  WIDTH  result, or low product, or quotient.
- out_hi  output  WIDTH  high product or remainder; 0 for single-cycle ops.
- zero  output  1  out == 0, registered with out.
- div_zero  output  1  divu with inp2 == 0.
- illegal  output  1  op 101, or mulu/divu while ALU_MULDIV_EN is undefined.

Behaviour:
- Reset (rst_n=0, asynchronous): busy=0, done=0, out=0, out_hi=0, zero=0, div_zero=0, illegal=0, counter=0. FSM goes to IDLE.
- Reset mid-operation aborts immediately; no done is produced for the aborted op.
- FSM states are IDLE, MUL, DIV, FIN.
- Operands and op are captured at the accepting edge. Later changes to inp1/inp2/op do not affect an op in flight.
- start while busy=1 is ignored and not queued.
- Single-cycle ops (and/or/add/sub/slt, illegal, div-by-zero): start accepted at edge N. done=1 and results valid in cycle N+1. busy stays 0. The FSM goes IDLE -> FIN -> IDLE.
- Back-to-back single-cycle ops are allowed: start may be held high every cycle for one result per cycle.
- add/sub: modulo 2^WIDTH, carry discarded.
- slt: out=1 if inp1 < inp2 signed, else 0. Computed from the full comparison, not the sub sign bit, so overflow cases are correct.
- mulu: shift-add, one multiplier bit per cycle.
  - busy=1 for exactly WIDTH cycles (N+1 .. N+WIDTH).
  - done in cycle N+WIDTH+1, with busy=0 in that cycle.
  - {out_hi,out} = full 2*WIDTH-bit unsigned product.
- divu: restoring divide, one quotient bit per cycle, same timing as mulu.
  - out = quotient, out_hi = remainder.
- divu with inp2=0: single-cycle path. out = all ones, out_hi = inp1, div_zero=1.
- illegal op: single-cycle path. out=0, out_hi=0, illegal=1, zero=1.
- zero, div_zero and illegal update only on the done cycle and hold until the next done.
- out/out_hi hold their last result between operations.
- done is exactly 1 cycle wide.
- Counter runs from 0 to WIDTH-1, exits to FIN on WIDTH-1, then resets to 0.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: MUL/DIV states and the shift-add/restoring datapath are built, as described above.
- Undefined: no MUL/DIV logic is synthesised. mulu/divu take the single-cycle illegal path: done at N+1, out=0, out_hi=0, illegal=1, busy never asserts.
- All other ops are identical with or without the macro.

Test Plan (WIDTH=32, ALU_MULDIV_EN defined unless noted):
- Reset/idle: assert rst_n=0 mid-mulu (busy=1) -> busy, done, out, out_hi and all flags go 0 asynchronously. No done after release.
- Single-cycle ops:
  - add 0xFFFFFFFF+1 -> out=0, zero=1.
  - slt 0x80000000,0x7FFFFFFF -> out=1.
  - slt 0x7FFFFFFF,0x80000000 -> out=0.
  - done 1 cycle after start; 3 back-to-back starts -> 3 consecutive done pulses.
- mulu 0xFFFFFFFF*0xFFFFFFFF:
  - busy high exactly 32 cycles; done at start+33.
  - out=0x00000001, out_hi=0xFFFFFFFE.
  - start pulsed mid-op is ignored.
- divu 100/7 -> out=14, out_hi=2, done at start+33.
- divu 5/0 -> done at start+1, out=0xFFFFFFFF, out_hi=5, div_zero=1, busy never high.
- ALU_MULDIV_EN undefined: op=011 and op=101 -> done at start+1, illegal=1, out=0, zero=1.

Source files
------------

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: and/or/add/sub/slt single-cycle, shift-add mulu and restoring divu.
// Optional MUL/DIV datapath is built only when ALU_MULDIV_EN is defined.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             zero,
    output logic             div_zero,
    output logic             illegal
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] out_hi_q, out_hi_d;
    logic             zero_q, zero_d;
    logic             div_zero_q, div_zero_d;
    logic             illegal_q, illegal_d;
    logic             done_q, done_d;

    logic             fin_wr;
    logic [WIDTH-1:0] fin_lo;
    logic [WIDTH-1:0] fin_hi;
    logic             fin_dz;
    logic             fin_ill;

`ifdef ALU_MULDIV_EN
    // hi/lo form the shared shift pair: partial product/multiplier, or remainder/dividend.
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             last_step;
`endif

    always_comb begin
        state_d = state_q;
        fin_wr  = 1'b0;
        fin_lo  = '0;
        fin_hi  = '0;
        fin_dz  = 1'b0;
        fin_ill = 1'b0;
`ifdef ALU_MULDIV_EN
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_sh    = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_sh - {1'b0, b_q};
        last_step = (cnt_q == CNT_W'(WIDTH - 1));
`endif
        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (start) begin
                    fin_wr  = 1'b1;
                    state_d = FIN;
                    case (op)
                        3'b000: fin_lo = inp1 & inp2;
                        3'b001: fin_lo = inp1 | inp2;
                        3'b010: fin_lo = inp1 + inp2;
                        3'b110: fin_lo = inp1 - inp2;
                        3'b111: fin_lo = {{(WIDTH-1){1'b0}}, ($signed(inp1) < $signed(inp2))};
`ifdef ALU_MULDIV_EN
                        3'b011: begin
                            fin_wr  = 1'b0;
                            state_d = MUL;
                            hi_d    = '0;
                            lo_d    = inp2;
                            b_d     = inp1;
                            cnt_d   = '0;
                        end
                        3'b100: begin
                            if (inp2 == '0) begin
                                fin_lo = '1;
                                fin_hi = inp1;
                                fin_dz = 1'b1;
                            end else begin
                                fin_wr  = 1'b0;
                                state_d = DIV;
                                hi_d    = '0;
                                lo_d    = inp1;
                                b_d     = inp2;
                                cnt_d   = '0;
                            end
                        end
`endif
                        default: fin_ill = 1'b1;
                    endcase
                end
            end
`ifdef ALU_MULDIV_EN
            MUL: begin
                {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
                cnt_d        = cnt_q + CNT_W'(1);
                if (last_step) begin
                    state_d = FIN;
                    cnt_d   = '0;
                    fin_wr  = 1'b1;
                    fin_lo  = lo_d;
                    fin_hi  = hi_d;
                end
            end
            DIV: begin
                // A clear borrow bit means the shifted remainder covered the divisor.
                hi_d  = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
                lo_d  = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    state_d = FIN;
                    cnt_d   = '0;
                    fin_wr  = 1'b1;
                    fin_lo  = lo_d;
                    fin_hi  = hi_d;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        done_d     = fin_wr;
        out_d      = fin_wr ? fin_lo : out_q;
        out_hi_d   = fin_wr ? fin_hi : out_hi_q;
        zero_d     = fin_wr ? (fin_lo == '0) : zero_q;
        div_zero_d = fin_wr ? fin_dz : div_zero_q;
        illegal_d  = fin_wr ? fin_ill : illegal_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            out_q      <= '0;
            out_hi_q   <= '0;
            zero_q     <= 1'b0;
            div_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            out_hi_q   <= out_hi_d;
            zero_q     <= zero_d;
            div_zero_q <= div_zero_d;
            illegal_q  <= illegal_d;
            done_q     <= done_d;
        end
    end

`ifdef ALU_MULDIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end
`endif

    assign busy     = (state_q == MUL) || (state_q == DIV);
    assign done     = done_q;
    assign out      = out_q;
    assign out_hi   = out_hi_q;
    assign zero     = zero_q;
    assign div_zero = div_zero_q;
    assign illegal  = illegal_q;
endmodule
